// File: rtl/mult_pipe.sv
// -----------------------------------------------------------------------------
// mult_pipe -- fully pipelined WIDTH x WIDTH integer multiplier.
//
// The operands, the per-beat signed_mode bit and a valid bit are registered in
// an input stage. STAGES-1 product stages follow. The first product stage does
// the multiply and the rest delay the result, so y is visible STAGES cycles
// after a beat is presented. Every stage shifts together on a single advance
// enable. A held output therefore freezes the whole pipe, and bubbles travel
// through it as invalid stages.
//
// Optional feature (compile-time macro MULT_PIPE_ACC_EN): adds acc_clr/acc and
// an ACC_WIDTH accumulator that sums each product as it leaves the block.
//
// Parameters:
//   WIDTH     operand width (>= 2); y is 2*WIDTH bits
//   STAGES    register stages from accepted input to y (>= 2)
//   ACC_WIDTH accumulator width (>= 2*WIDTH), used only with MULT_PIPE_ACC_EN
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    input handshake (in_ready depends only on the output side)
//   a, b, signed_mode      operands, 1 = two's complement, 0 = unsigned
//   out_valid / out_ready  output handshake
//   y                      product (low 2*WIDTH bits of the exact product)
//   acc_clr, acc           accumulator clear / value (MULT_PIPE_ACC_EN only)
// -----------------------------------------------------------------------------
module mult_pipe #(
  parameter int WIDTH     = 16,
  parameter int STAGES    = 3,
  parameter int ACC_WIDTH = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   signed_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     y
`ifdef MULT_PIPE_ACC_EN
  ,
  input  logic                   acc_clr,
  output logic [ACC_WIDTH-1:0]   acc
`endif
);

  localparam int PS = STAGES - 1;   // number of product stages

  if (STAGES < 2) begin : g_bad_stages
    $error("mult_pipe: STAGES must be at least 2");
  end

  // Whole-pipe advance: move when the output slot is empty or being drained.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Input stage
  logic [WIDTH-1:0] a_q, b_q;
  logic             sm_in_q;
  logic             v_in_q;

  // Product stages, index PS-1 drives the outputs
  logic [2*WIDTH-1:0] p_q  [PS];
  logic [PS-1:0]      v_q;
  logic [PS-1:0]      sm_q;

  // Extending both operands to 2*WIDTH bits (sign or zero per mode) and
  // multiplying modulo 2^(2*WIDTH) gives exactly the low 2*WIDTH bits of the
  // (WIDTH+1)-bit extended product. No wider intermediate is required.
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;

  // NOTE: every variable written in always_comb gets a default value first,
  // so that no path leaves it unassigned and infers a latch.
  always_comb begin
    ext_a = {{WIDTH{1'b0}}, a_q};
    ext_b = {{WIDTH{1'b0}}, b_q};
    if (sm_in_q) begin
      ext_a = {{WIDTH{a_q[WIDTH-1]}}, a_q};
      ext_b = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    end
    prod = ext_a * ext_b;
  end

  // NOTE: the data registers are reset as well as the valid bits, so y reads 0
  // after reset. Sequential state uses non-blocking assignments only, which
  // keeps the stage-to-stage shift order independent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sm_in_q <= 1'b0;
      v_in_q  <= 1'b0;
      v_q     <= '0;
      sm_q    <= '0;
      for (int k = 0; k < PS; k++) p_q[k] <= '0;
    end else if (adv) begin
      v_in_q  <= in_valid;
      a_q     <= a;
      b_q     <= b;
      sm_in_q <= signed_mode;
      p_q[0]  <= prod;
      v_q[0]  <= v_in_q;
      sm_q[0] <= sm_in_q;
      for (int k = 1; k < PS; k++) begin
        p_q[k]  <= p_q[k-1];
        v_q[k]  <= v_q[k-1];
        sm_q[k] <= sm_q[k-1];
      end
    end
  end

  assign out_valid = v_q[PS-1];
  assign y         = p_q[PS-1];

`ifdef MULT_PIPE_ACC_EN
  // Extend the output product per its own beat's mode before accumulating.
  logic [ACC_WIDTH-1:0] y_ext;
  always_comb begin
    y_ext = ACC_WIDTH'(y);
    if (sm_q[PS-1]) y_ext = ACC_WIDTH'($signed(y));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (out_valid && out_ready) begin
      // A clear that coincides with a transfer restarts the sum at this product.
      acc <= (acc_clr ? '0 : acc) + y_ext;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end
`else
  logic unused_sm;
  assign unused_sm = ^sm_q;
`endif

endmodule

// File: doc/mult_pipe.md
Name: mult_pipe

Overview:
Parametrised, fully pipelined integer multiplier with per-beat signed/unsigned mode and a valid/ready handshake on both sides.
- Registered operands feed a configurable number of product pipeline stages. Sustains one product per cycle and stalls cleanly under downstream backpressure.
- Drop-in datapath multiplier for the filter and MAC blocks. An optional accumulator turns it into a streaming MAC.

Parameters:
- WIDTH, 16, operand width in bits (≥2); product is 2*WIDTH bits.
- STAGES, 3, register stages from accepted input to y (≥2): 1 input stage plus STAGES-1 product stages. STAGES<2 is an elaboration error.
- ACC_WIDTH, 40, accumulator width (≥2*WIDTH). Used only with MULT_PIPE_ACC_EN.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, a/b/signed_mode valid this cycle.
- in_ready, output, 1, block accepts a beat this cycle.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- signed_mode, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled with the beat.
- out_valid, output, 1, y holds a valid product.
- out_ready, input, 1, consumer accepts y this cycle.
- y, output, 2*WIDTH, product.
- acc_clr, input, 1, synchronous accumulator clear (only with MULT_PIPE_ACC_EN).
- acc, output, ACC_WIDTH, accumulator value (only with MULT_PIPE_ACC_EN).

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits = 0, all data registers = 0. out_valid=0, y=0, acc=0. in_ready is 1 once rst_n is released.
- Advance enable: adv = !out_valid | out_ready. All stages shift together when adv=1 and hold all contents when adv=0.
- in_ready = adv, combinational from out_valid/out_ready. Has no combinational path from in_valid.
- Input accept: in_valid & in_ready. Stage-1 valid loads in_valid whenever adv=1, so bubbles propagate as invalid stages.
- Latency: with no stall, a beat accepted at edge N appears on y/out_valid after edge N+STAGES-1, i.e. visible STAGES cycles after presentation.
- Throughput: 1 beat/cycle while out_ready=1. No beat is lost or duplicated under any in_valid/out_ready pattern.
- Output transfer: out_valid & out_ready. y is stable while out_valid=1 and out_ready=0.
- Arithmetic:
  - signed_mode=1: operands sign-extended to WIDTH+1 bits.
  - signed_mode=0: operands zero-extended to WIDTH+1 bits.
  - y = low 2*WIDTH bits of the product, which is exact in both modes.
  - Signed example: -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2).
  - Unsigned example: (2^WIDTH-1)^2 = 0xFFFE0001 for WIDTH=16.
- signed_mode travels with its beat through every stage. Mixing modes on consecutive beats is legal.
- The multiply is split or retimed freely across the STAGES-1 product stages. Only the latency and values above are contractual.
- Reset mid-stream: every in-flight beat is discarded, out_valid drops asynchronously, and no partial result is emitted after release.

Optional Feature:
MULT_PIPE_ACC_EN
- Defined: acc_clr and acc ports exist, and an ACC_WIDTH register accumulates products.
  - Update condition: only on an output transfer (out_valid & out_ready). Stalled or invalid cycles do not update acc.
  - Each product is extended to ACC_WIDTH per its beat's signed_mode (sign- or zero-extend) before adding. Overflow wraps modulo 2^ACC_WIDTH.
  - acc_clr=1 without a transfer: acc becomes 0.
  - acc_clr=1 together with a transfer: acc becomes the extended product of that transfer (clear, then add).
  - acc updates one edge after the transfer and is registered.
- Undefined: the ports and accumulator are absent, and the block is a pure pipelined multiplier.

Test Plan:
- WIDTH=16, STAGES=3, out_ready=1, unsigned 0xFFFF*0xFFFF -> y=0xFFFE0001 with out_valid exactly 3 cycles after presentation.
- Signed beats back-to-back: 0x8000*0x8000, then 0xFFFF*0x0002, then 0x7FFF*0x8000 -> y=0x40000000, 0xFFFFFFFE, 0xC0008000 on consecutive cycles.
- Stream 20 random mixed-mode beats with random out_ready and in_valid gaps -> outputs match a reference model in order, with no drops or duplicates; y is held while stalled and in_ready=0 whenever out_valid=1 and out_ready=0.
- Assert rst_n low while 2 beats are in flight -> out_valid=0 and y=0 immediately; after release, no stale beat appears.
- MULT_PIPE_ACC_EN, ACC_WIDTH=40, signed: 3 transfers of 0xFFFF*0x0001 -> acc=0xFFFFFFFFFD. Then acc_clr together with 5*3 transferring -> acc=15.
- MULT_PIPE_ACC_EN, unsigned 0xFFFF*0xFFFF repeated 257 times -> acc equals 257*0xFFFE0001 mod 2^40 (wrap-around checked).
